// File: rtl/mem_arbiter.sv
// Two-port to single-port memory arbiter for the LC-3b pipeline: instruction port A
// and data port B share one physical memory port under round-robin arbitration.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int WIDTH = 16,
    parameter int MASKW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read_a,
    input  logic [WIDTH-1:0] mem_address_a,
    output logic             mem_resp_a,
    output logic [WIDTH-1:0] mem_rdata_a,
    input  logic             mem_read_b,
    input  logic             mem_write_b,
    input  logic [MASKW-1:0] mem_wmask_b,
    input  logic [WIDTH-1:0] mem_address_b,
    input  logic [WIDTH-1:0] mem_wdata_b,
    output logic             mem_resp_b,
    output logic [WIDTH-1:0] mem_rdata_b,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [MASKW-1:0] pmem_wmask,
    output logic [WIDTH-1:0] pmem_address,
    output logic [WIDTH-1:0] pmem_wdata,
    input  logic             pmem_resp,
    input  logic [WIDTH-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last_b;
    logic             r_op_read;
    logic             r_op_write;
    logic [WIDTH-1:0] r_address;
    logic [WIDTH-1:0] r_wdata;
    logic [MASKW-1:0] r_wmask;

    logic w_req_a;
    logic w_req_b;
    logic w_grant_a;
    logic w_grant_b;
    logic w_serving;

    assign w_req_a = mem_read_a;
    assign w_req_b = mem_read_b | mem_write_b;

    // On a tie the port that was not granted last wins.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (r_state == IDLE) begin
            if (w_req_a && w_req_b) begin
                w_grant_a = r_last_b;
                w_grant_b = ~r_last_b;
            end else begin
                w_grant_a = w_req_a;
                w_grant_b = w_req_b;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_a) begin
                    w_next = SERVE_A;
                end else if (w_grant_b) begin
                    w_next = SERVE_B;
                end
            end
            SERVE_A, SERVE_B: begin
                if (pmem_resp) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last_b   <= 1'b0;
            r_op_read  <= 1'b0;
            r_op_write <= 1'b0;
            r_address  <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_a) begin
                r_last_b   <= 1'b0;
                r_op_read  <= 1'b1;
                r_op_write <= 1'b0;
                r_address  <= mem_address_a;
                r_wdata    <= '0;
                r_wmask    <= '1;
            end else if (w_grant_b) begin
                // A simultaneous read and write on port B is taken as a write.
                r_last_b   <= 1'b1;
                r_op_read  <= ~mem_write_b;
                r_op_write <= mem_write_b;
                r_address  <= mem_address_b;
                r_wdata    <= mem_wdata_b;
                r_wmask    <= mem_wmask_b;
            end
        end
    end

    always_comb begin
        w_serving    = (r_state == SERVE_A) || (r_state == SERVE_B);
        pmem_read    = w_serving & r_op_read;
        pmem_write   = w_serving & r_op_write;
        pmem_address = r_address;
        pmem_wdata   = r_wdata;
        pmem_wmask   = r_wmask;
        mem_resp_a   = (r_state == SERVE_A) && pmem_resp;
        mem_resp_b   = (r_state == SERVE_B) && pmem_resp;
        mem_rdata_a  = mem_resp_a ? pmem_rdata : '0;
        mem_rdata_b  = mem_resp_b ? pmem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester agents, a pmem responder model and
// one monitor that checks pmem requests, port responses and directed spot values.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int K_STROBE = 0;
    localparam int K_ADDR   = 1;
    localparam int K_WDATA  = 2;
    localparam int K_WMASK  = 3;
    localparam int K_RESP   = 4;
    localparam int K_PEND   = 5;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wmask;
    } pm_t;

    typedef struct {
        bit          port;
        logic [15:0] rdata;
    } rsp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wmask;
        bit          scramble;
    } breq_t;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } spot_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_a;
    logic [15:0] mem_address_a;
    logic        mem_resp_a;
    logic [15:0] mem_rdata_a;
    logic        mem_read_b;
    logic        mem_write_b;
    logic [1:0]  mem_wmask_b;
    logic [15:0] mem_address_b;
    logic [15:0] mem_wdata_b;
    logic        mem_resp_b;
    logic [15:0] mem_rdata_b;
    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  pmem_wmask;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;

    pm_t         exp_pm[$];
    rsp_t        exp_rsp[$];
    logic [15:0] a_q[$];
    breq_t       b_q[$];
    spot_t       spot_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int lat    = 1;
    bit auto_en = 1'b1;
    bit inject  = 1'b0;
    bit a_busy;
    bit b_busy;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(16), .MASKW(2)) dut (
        .clk(clk), .reset(reset),
        .mem_read_a(mem_read_a), .mem_address_a(mem_address_a),
        .mem_resp_a(mem_resp_a), .mem_rdata_a(mem_rdata_a),
        .mem_read_b(mem_read_b), .mem_write_b(mem_write_b),
        .mem_wmask_b(mem_wmask_b), .mem_address_b(mem_address_b),
        .mem_wdata_b(mem_wdata_b), .mem_resp_b(mem_resp_b), .mem_rdata_b(mem_rdata_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    function automatic logic [15:0] pm_data(input logic [15:0] a);
        return (a == 16'h0040) ? 16'h1234 : (a ^ 16'hA5C3);
    endfunction

    function automatic pm_t mkpm(input logic rd, input logic wr, input logic [15:0] ad,
                                 input logic [15:0] wd, input logic [1:0] wm);
        pm_t p;
        p.rd = rd; p.wr = wr; p.addr = ad; p.wdata = wd; p.wmask = wm;
        return p;
    endfunction

    task automatic spot(input int k, input logic [31:0] e, input string nm);
        spot_t s;
        s.kind = k; s.exp = e; s.name = nm;
        spot_q.push_back(s);
    endtask

    task automatic push_rsp(input bit port, input logic [15:0] d);
        rsp_t r;
        r.port = port; r.rdata = d;
        exp_rsp.push_back(r);
    endtask

    task automatic push_b(input logic rd, input logic wr, input logic [15:0] ad,
                          input logic [15:0] wd, input logic [1:0] wm, input bit scr);
        breq_t r;
        r.rd = rd; r.wr = wr; r.addr = ad; r.wdata = wd; r.wmask = wm; r.scramble = scr;
        b_q.push_back(r);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((a_q.size() > 0 || b_q.size() > 0 || a_busy || b_busy || exp_rsp.size() > 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        spot(K_PEND, 32'd0, "drain_pending");
        @(negedge clk); #1;
    endtask

    // pmem responder: decides at the falling edge, drives just after the rising edge.
    initial begin
        int          cnt;
        bit          st, inj, fire;
        logic [15:0] ad;
        cnt = 0;
        pmem_resp = 1'b0;
        pmem_rdata = 16'hDEAD;
        forever begin
            @(negedge clk);
            st = pmem_read | pmem_write;
            inj = inject;
            ad = pmem_address;
            fire = 1'b0;
            if (pmem_resp || !auto_en || !st) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= lat) begin
                    fire = 1'b1;
                    cnt = 0;
                end
            end
            if (inj) fire = 1'b1;
            @(posedge clk); #1;
            pmem_resp  = fire;
            pmem_rdata = fire ? pm_data(ad) : 16'hDEAD;
        end
    end

    initial begin
        bit done, rst;
        mem_read_a = 1'b0;
        mem_address_a = '0;
        a_busy = 1'b0;
        forever begin
            @(negedge clk);
            done = mem_resp_a;
            rst = reset;
            @(posedge clk); #1;
            if (rst || (a_busy && done)) begin
                mem_read_a = 1'b0;
                a_busy = 1'b0;
            end
            if (!rst && !a_busy && a_q.size() > 0) begin
                mem_address_a = a_q.pop_front();
                mem_read_a = 1'b1;
                a_busy = 1'b1;
            end
        end
    end

    initial begin
        bit    done, rst, sb, scr;
        breq_t r;
        mem_read_b = 1'b0;
        mem_write_b = 1'b0;
        mem_wmask_b = '0;
        mem_address_b = '0;
        mem_wdata_b = '0;
        b_busy = 1'b0;
        scr = 1'b0;
        forever begin
            @(negedge clk);
            done = mem_resp_b;
            rst = reset;
            sb = pmem_read | pmem_write;
            @(posedge clk); #1;
            if (rst || (b_busy && done)) begin
                mem_read_b = 1'b0;
                mem_write_b = 1'b0;
                b_busy = 1'b0;
            end else if (b_busy && scr && sb) begin
                mem_address_b = 16'hFFFF;
                mem_wdata_b = 16'h5555;
                mem_wmask_b = 2'b00;
            end
            if (!rst && !b_busy && b_q.size() > 0) begin
                r = b_q.pop_front();
                mem_read_b = r.rd;
                mem_write_b = r.wr;
                mem_address_b = r.addr;
                mem_wdata_b = r.wdata;
                mem_wmask_b = r.wmask;
                scr = r.scramble;
                b_busy = 1'b1;
            end
        end
    end

    initial begin
        spot_t       s;
        rsp_t        e;
        pm_t         obs_pm;
        logic [31:0] obs;
        logic [15:0] d;
        bit          port;
        forever begin
            @(negedge clk);
            while (spot_q.size() > 0) begin
                s = spot_q.pop_front();
                case (s.kind)
                    K_STROBE: obs = {30'd0, pmem_read, pmem_write};
                    K_ADDR:   obs = {16'd0, pmem_address};
                    K_WDATA:  obs = {16'd0, pmem_wdata};
                    K_WMASK:  obs = {30'd0, pmem_wmask};
                    K_RESP:   obs = {30'd0, mem_resp_a, mem_resp_b};
                    default:  obs = 32'(exp_rsp.size() + exp_pm.size() + a_q.size() + b_q.size());
                endcase
                n_cmp++;
                if (obs !== s.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", s.name, obs, s.exp);
                end
            end
            if (pmem_read || pmem_write) begin
                n_cmp++;
                obs_pm = mkpm(pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask);
                if (exp_pm.size() == 0) begin
                    n_fail++;
                    $display("FAIL pmem_unexpected: got %h expected no request", obs_pm);
                end else begin
                    if (obs_pm !== exp_pm[0]) begin
                        n_fail++;
                        $display("FAIL pmem_req: got %h expected %h", obs_pm, exp_pm[0]);
                    end
                    if (pmem_resp) void'(exp_pm.pop_front());
                end
            end
            if (reset) exp_pm.delete();
            if (mem_resp_a || mem_resp_b) begin
                n_cmp++;
                port = mem_resp_b;
                d = port ? mem_rdata_b : mem_rdata_a;
                if (mem_resp_a && mem_resp_b) begin
                    n_fail++;
                    $display("FAIL resp_both: got a=1 b=1 expected one port");
                end else if (exp_rsp.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: got port %0d data %h expected none", port, d);
                end else begin
                    e = exp_rsp.pop_front();
                    if (port !== e.port || d !== e.rdata) begin
                        n_fail++;
                        $display("FAIL resp: got port %0d data %h expected port %0d data %h",
                                 port, d, e.port, e.rdata);
                    end
                end
            end
            if (!mem_resp_a) begin
                n_cmp++;
                if (mem_rdata_a !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL rdata_a_idle: got %h expected 0000", mem_rdata_a);
                end
            end
            if (!mem_resp_b) begin
                n_cmp++;
                if (mem_rdata_b !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL rdata_b_idle: got %h expected 0000", mem_rdata_b);
                end
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        spot(K_STROBE, 32'd0, "rst_strobe");
        spot(K_ADDR,   32'd0, "rst_addr");
        spot(K_WDATA,  32'd0, "rst_wdata");
        spot(K_WMASK,  32'd0, "rst_wmask");
        spot(K_RESP,   32'd0, "rst_resp");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;

        // Tie after reset grants B; B re-requests at once and the next tie grants A.
        lat = 1;
        push_b(1'b1, 1'b0, 16'h2000, 16'h0000, 2'b00, 1'b0);
        push_b(1'b1, 1'b0, 16'h2002, 16'h0000, 2'b00, 1'b0);
        a_q.push_back(16'h0000);
        exp_pm.push_back(mkpm(1'b1, 1'b0, 16'h2000, 16'h0000, 2'b00));
        exp_pm.push_back(mkpm(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b11));
        exp_pm.push_back(mkpm(1'b1, 1'b0, 16'h2002, 16'h0000, 2'b00));
        push_rsp(1'b1, 16'h85C3);
        push_rsp(1'b0, 16'hA5C3);
        push_rsp(1'b1, 16'h85C1);
        drain(200);

        lat = 3;
        a_q.push_back(16'h0040);
        exp_pm.push_back(mkpm(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11));
        push_rsp(1'b0, 16'h1234);
        drain(200);

        lat = 2;
        push_b(1'b0, 1'b1, 16'h1001, 16'hAB00, 2'b10, 1'b0);
        exp_pm.push_back(mkpm(1'b0, 1'b1, 16'h1001, 16'hAB00, 2'b10));
        push_rsp(1'b1, 16'hB5C2);
        drain(200);

        lat = 3;
        push_b(1'b1, 1'b0, 16'h3000, 16'h1111, 2'b01, 1'b1);
        exp_pm.push_back(mkpm(1'b1, 1'b0, 16'h3000, 16'h1111, 2'b01));
        push_rsp(1'b1, 16'h95C3);
        drain(200);

        lat = 1;
        push_b(1'b1, 1'b1, 16'h0500, 16'h00CD, 2'b01, 1'b0);
        exp_pm.push_back(mkpm(1'b0, 1'b1, 16'h0500, 16'h00CD, 2'b01));
        push_rsp(1'b1, 16'hA0C3);
        drain(200);

        // Reset during SERVE_A, then a stray pmem_resp lands while IDLE.
        auto_en = 1'b0;
        a_q.push_back(16'h0300);
        exp_pm.push_back(mkpm(1'b1, 1'b0, 16'h0300, 16'h0000, 2'b11));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pmem_read || pmem_write) && n < 20);
        @(posedge clk); #1;
        reset = 1'b1;
        inject = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        inject = 1'b0;
        spot(K_STROBE, 32'd0, "abort_strobe");
        spot(K_RESP,   32'd0, "abort_resp");
        spot(K_ADDR,   32'd0, "abort_addr");
        @(posedge clk); #1;
        spot(K_STROBE, 32'd0, "abort_idle_strobe");
        auto_en = 1'b1;
        @(negedge clk); #1;
        drain(50);

        // last_grant is back to A, so this tie grants B first.
        lat = 2;
        push_b(1'b1, 1'b0, 16'h2000, 16'h0000, 2'b00, 1'b0);
        a_q.push_back(16'h0000);
        exp_pm.push_back(mkpm(1'b1, 1'b0, 16'h2000, 16'h0000, 2'b00));
        exp_pm.push_back(mkpm(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b11));
        push_rsp(1'b1, 16'h85C3);
        push_rsp(1'b0, 16'hA5C3);
        drain(200);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
